// File: rtl/adc_axis_streamer.sv
// ADC sample capture into a DEPTH-entry FIFO, presented as a 24-bit AXI-Stream master with overflow counting.
// Define ADC_AXIS_STREAMER_TLAST_EN to add m_axis_tlast frame marking every FRAME_LEN samples per tag run.
module adc_axis_streamer #(
  parameter int DATA_W    = 24,
  parameter int USER_W    = 2,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_W-1:0]      adc_data,
  input  logic                   adc_strobe,
  input  logic [USER_W-1:0]      mode_sel,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [USER_W-1:0]      m_axis_tuser,
`ifdef ADC_AXIS_STREAMER_TLAST_EN
  output logic                   m_axis_tlast,
`endif
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       overflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || FRAME_LEN < 1) begin : g_param_check
    $error("adc_axis_streamer: DEPTH must be a power of 2 in 2..256 and FRAME_LEN must be >= 1");
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             empty, full, push, pop, drop;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    // A strobe into a full FIFO is dropped even if a pop frees a slot on the same edge.
    push     = adc_strobe && !full;
    drop     = adc_strobe && full;
    pop      = !empty && m_axis_tready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (drop && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read after the level shows it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_t'{data: adc_data, user: mode_sel};
  end

  // Outputs come only from stored state; zeroed while empty so reset presents all-zero outputs.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    m_axis_tvalid = !empty;
    m_axis_tdata  = empty ? '0 : head.data;
    m_axis_tuser  = empty ? '0 : head.user;
    fifo_level    = level_q;
    overflow_cnt  = ovf_q;
  end

`ifdef ADC_AXIS_STREAMER_TLAST_EN
  localparam int FR_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [FR_W-1:0]   frame_idx_q, frame_idx_d, head_idx;
  logic [USER_W-1:0] last_user_q, last_user_d;

  // A head whose tag differs from the last popped sample starts a new frame at index 0.
  always_comb begin
    head_idx     = (head.user != last_user_q) ? '0 : frame_idx_q;
    m_axis_tlast = !empty && (head_idx == FR_W'(FRAME_LEN - 1));
    frame_idx_d  = frame_idx_q;
    last_user_d  = last_user_q;
    if (pop) begin
      frame_idx_d = m_axis_tlast ? '0 : head_idx + 1'b1;
      last_user_d = head.user;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      frame_idx_q <= '0;
      last_user_q <= '0;
    end else begin
      frame_idx_q <= frame_idx_d;
      last_user_q <= last_user_d;
    end
  end
`endif

endmodule

// File: tb/tb_adc_axis_streamer.sv
// Directed bench for adc_axis_streamer: queue-based reference model checked every cycle plus literal expectations.
module tb_adc_axis_streamer;

  localparam int DATA_W    = 24;
  localparam int USER_W    = 2;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 4;
  localparam int FRAME_LEN = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_strobe = 1'b0;
  logic [USER_W-1:0] mode_sel = '0;
  logic              m_axis_tready = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic [USER_W-1:0] m_axis_tuser;
  logic [3:0]        fifo_level;
  logic [CNT_W-1:0]  overflow_cnt;
`ifdef ADC_AXIS_STREAMER_TLAST_EN
  logic              m_axis_tlast;
`endif

  adc_axis_streamer #(
    .DATA_W(DATA_W), .USER_W(USER_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .adc_data     (adc_data),
    .adc_strobe   (adc_strobe),
    .mode_sel     (mode_sel),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
`ifdef ADC_AXIS_STREAMER_TLAST_EN
    .m_axis_tlast (m_axis_tlast),
`endif
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored samples, a saturating drop count, and the run length of the current tag.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
  } ent_t;

  ent_t              q[$];
  int                m_ovf = 0;
  int                m_run = 0;
  logic [USER_W-1:0] m_last_user = '0;
  bit                m_full;
  bit                cmp_en = 1'b0;

  function automatic int head_index();
    return (q[0].user == m_last_user) ? m_run : 0;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      m_ovf       = 0;
      m_run       = 0;
      m_last_user = '0;
    end else begin
      m_full = (q.size() == DEPTH);
      if (q.size() != 0 && m_axis_tready) begin
        m_run       = head_index() + 1;
        m_last_user = q[0].user;
        void'(q.pop_front());
      end
      if (adc_strobe) begin
        if (m_full) begin
          if (m_ovf < (2 ** CNT_W) - 1) m_ovf++;
        end else begin
          q.push_back('{adc_data, mode_sel});
        end
      end
    end
  end

  // Per-cycle compare plus the hold-under-backpressure property.
  logic              stall_q = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [USER_W-1:0] prev_user = '0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("tvalid", m_axis_tvalid, q.size() != 0);
      check("fifo_level", fifo_level, q.size());
      check("overflow_cnt", overflow_cnt, m_ovf);
      if (q.size() != 0) begin
        check("tdata", m_axis_tdata, q[0].data);
        check("tuser", m_axis_tuser, q[0].user);
`ifdef ADC_AXIS_STREAMER_TLAST_EN
        check("tlast", m_axis_tlast, (head_index() % FRAME_LEN) == FRAME_LEN - 1);
`endif
      end
      if (stall_q && m_axis_tvalid) begin
        check("hold_tdata", m_axis_tdata, prev_data);
        check("hold_tuser", m_axis_tuser, prev_user);
      end
      stall_q   = m_axis_tvalid && !m_axis_tready && rstn;
      prev_data = m_axis_tdata;
      prev_user = m_axis_tuser;
    end
  end

  // Record what actually leaves the DUT for literal order/tlast expectations.
  logic [DATA_W-1:0] popped[$];
  logic              popped_last[$];

  always @(negedge clk) begin
    if (rstn && m_axis_tvalid && m_axis_tready) begin
      popped.push_back(m_axis_tdata);
`ifdef ADC_AXIS_STREAMER_TLAST_EN
      popped_last.push_back(m_axis_tlast);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] d, input logic [USER_W-1:0] u);
    adc_data   = d;
    mode_sel   = u;
    adc_strobe = 1'b1;
    tick();
    adc_strobe = 1'b0;
  endtask

  task automatic drain(input int max_cycles, input bit random_ready);
    int n = 0;
    while (fifo_level != 0 && n < max_cycles) begin
      m_axis_tready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    m_axis_tready = 1'b0;
    check("drain_done", fifo_level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle.
    rstn = 1'b0;
    repeat (10) tick();
    cmp_en = 1'b1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow_cnt, 0);
    rstn = 1'b1;
    repeat (100) tick();
    check("idle_tvalid", m_axis_tvalid, 0);

    // Single sample: visible the cycle after the strobe edge, popped on the next edge.
    m_axis_tready = 1'b1;
    strobe(24'h123456, 2'd2);
    check("single_tvalid", m_axis_tvalid, 1);
    check("single_tdata", m_axis_tdata, 24'h123456);
    check("single_tuser", m_axis_tuser, 2);
    check("single_level", fifo_level, 1);
    tick();
    check("single_level_after", fifo_level, 0);
    check("single_tvalid_after", m_axis_tvalid, 0);

    // Backpressure and ordering with per-sample tags.
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 5; i++) strobe(DATA_W'(i), USER_W'(i % 4));
    check("bp_level", fifo_level, 5);
    check("bp_head", m_axis_tdata, 24'h000001);
    check("bp_head_tuser", m_axis_tuser, 1);
    popped.delete();
    drain(300, 1'b1);
    check("bp_count", popped.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < popped.size()) check("bp_order", popped[i], i + 1);

    // Overflow: 12 strobes into 8 slots.
    for (int i = 0; i < 12; i++) strobe(24'h000100 + DATA_W'(i), USER_W'(i % 4));
    check("ovf_level", fifo_level, 8);
    check("ovf_cnt", overflow_cnt, 4);

    // Strobe and pop on the same edge at full: sample dropped, one pop.
    popped.delete();
    m_axis_tready = 1'b1;
    strobe(24'hABCDEF, 2'd3);
    m_axis_tready = 1'b0;
    check("simul_ovf", overflow_cnt, 5);
    check("simul_level", fifo_level, 7);
    drain(50, 1'b0);
    check("ovf_drain_count", popped.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < popped.size()) check("ovf_intact", popped[i], 24'h000100 + i);

    // Reset while a transfer is pending drops tvalid on the next edge.
    for (int i = 0; i < 4; i++) strobe(24'h00AA00 + DATA_W'(i), 2'd1);
    m_axis_tready = 1'b1;
    rstn = 1'b0;
    tick();
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_ovf", overflow_cnt, 0);
    m_axis_tready = 1'b0;
    tick();
    rstn = 1'b1;

    // Saturation: 8 stored, 20 excess with a 4-bit counter.
    for (int i = 0; i < 28; i++) strobe(24'h00C000 + DATA_W'(i), 2'd0);
    check("sat_level", fifo_level, 8);
    check("sat_ovf", overflow_cnt, 15);
    strobe(24'h00DEAD, 2'd0);
    check("sat_hold", overflow_cnt, 15);
    drain(50, 1'b0);

`ifdef ADC_AXIS_STREAMER_TLAST_EN
    // Frames of 4: ten mode-0 samples, then four mode-1 samples.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    popped_last.delete();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) strobe(24'h00E000 + DATA_W'(i), 2'd0);
    for (int i = 0; i < 4; i++) strobe(24'h00F000 + DATA_W'(i), 2'd1);
    drain(20, 1'b0);
    check("tlast_count", popped_last.size(), 14);
    for (int i = 0; i < 14; i++)
      if (i < popped_last.size()) check("tlast_pattern", popped_last[i], (i == 3 || i == 7 || i == 13));

    // Reset mid-frame restarts the count.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 2; i++) strobe(24'h001000 + DATA_W'(i), 2'd0);
    drain(20, 1'b0);
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    popped_last.delete();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) strobe(24'h002000 + DATA_W'(i), 2'd0);
    drain(20, 1'b0);
    check("tlast_rst_count", popped_last.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < popped_last.size()) check("tlast_rst_pattern", popped_last[i], i == 3);
`endif

    repeat (3) tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
